fp_result_checker: RTL and testbench

- Synthesizable self-checking stage that sits directly downstream of fp_unit.
- Holds a FIFO of expected {result, flags} entries, pushed by the stimulus/vector source when it issues each operation to fp_unit.
- Pops one entry per fp_unit result and compares with NaN-payload masking.
- Keeps pass/fail counters, captures the first failure, and halts on mismatch when configured to.

---
 rtl/fp_result_checker_pkg.sv | 27 ++
 rtl/fp_chk_fifo.sv | 45 ++++
 rtl/fp_result_checker.sv | 124 ++++++++++++
 tb/tb_fp_result_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_result_checker_pkg.sv
// Shared types for the fp_unit result checker: expected-entry layout and NaN constants.
package fp_wire;

  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        canon;
  } fp_chk_entry_type;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;

  // Float-result ops may return the canonical NaN for any expected NaN: ignore sign and payload.
  function automatic logic [31:0] fp_masked_diff(input logic [31:0] exp_r,
                                                 input logic [31:0] res_r,
                                                 input logic        canon);
    logic [31:0] d;
    d = exp_r ^ res_r;
    if (canon && (res_r == FP_CANON_NAN)) begin
      d[31]   = 1'b0;
      d[21:0] = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/fp_chk_fifo.sv
// First-word-fall-through FIFO of expected entries; extra pointer MSB separates full from empty.
module fp_chk_fifo
  import fp_wire::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  fp_chk_entry_type din,
  output logic             full,
  output logic             empty,
  output fp_chk_entry_type dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  fp_chk_entry_type mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fp_result_checker.sv
// Checks fp_unit results against queued expectations; counts passes/fails and snapshots the first failure.
module fp_result_checker
  import fp_wire::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned STOP_ON_FAIL = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [31:0]      exp_result,
  input  logic [4:0]       exp_flags,
  input  logic             exp_canon,
  input  logic [31:0]      exp_data1,
  input  logic [31:0]      exp_data2,
  input  logic             res_valid,
  input  logic [31:0]      res_result,
  input  logic [4:0]       res_flags,
  input  logic             clear,
  output logic             busy,
  output logic             halted,
  output logic             chk_valid,
  output logic             chk_fail,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_underflow,
  output logic [31:0]      err_data1,
  output logic [31:0]      err_data2,
  output logic [31:0]      err_expected,
  output logic [31:0]      err_calculated,
  output logic [4:0]       err_flags_exp,
  output logic [4:0]       err_flags_calc
);

  typedef enum logic {RUN, HALT} state_t;

  state_t           state;
  fp_chk_entry_type din;
  fp_chk_entry_type head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             underflow;
  logic             check;
  logic             mismatch;
  logic             fail_now;

  assign din       = '{data1: exp_data1, data2: exp_data2, result: exp_result,
                       flags: exp_flags, canon: exp_canon};
  assign exp_ready = !full && (state == RUN);
  assign busy      = !empty;
  assign halted    = (state == HALT);
  assign push      = exp_valid && exp_ready;
  assign pop       = res_valid && !empty && (state == RUN);
  // Judged on pre-push occupancy: a same-cycle push cannot satisfy this result.
  assign underflow = res_valid && empty && (state == RUN);
  assign check     = pop || underflow;
  assign mismatch  = (fp_masked_diff(head.result, res_result, head.canon) != '0) ||
                     ((head.flags ^ res_flags) != '0);
  assign fail_now  = underflow || mismatch;

  fp_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= RUN;
      chk_valid      <= 1'b0;
      chk_fail       <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      err_underflow  <= 1'b0;
      err_data1      <= '0;
      err_data2      <= '0;
      err_expected   <= '0;
      err_calculated <= '0;
      err_flags_exp  <= '0;
      err_flags_calc <= '0;
    end else begin
      chk_valid <= check;
      chk_fail  <= check && fail_now;
      if (clear) begin
        state          <= RUN;
        pass_count     <= '0;
        fail_count     <= '0;
        err_underflow  <= 1'b0;
        err_data1      <= '0;
        err_data2      <= '0;
        err_expected   <= '0;
        err_calculated <= '0;
        err_flags_exp  <= '0;
        err_flags_calc <= '0;
      end else if (check) begin
        if (fail_now) begin
          if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
          if (underflow) err_underflow <= 1'b1;
          if (fail_count == '0) begin
            err_data1      <= underflow ? '0 : head.data1;
            err_data2      <= underflow ? '0 : head.data2;
            err_expected   <= underflow ? '0 : head.result;
            err_flags_exp  <= underflow ? '0 : head.flags;
            err_calculated <= res_result;
            err_flags_calc <= res_flags;
          end
          if (STOP_ON_FAIL != 0) state <= HALT;
        end else if (pass_count != '1) begin
          pass_count <= pass_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_result_checker.sv
// Directed bench for fp_result_checker: halting and non-halting instances checked with immediate assertions.
module tb_fp_result_checker;
  import fp_wire::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Instance A: STOP_ON_FAIL=1
  logic        exp_valid = 0, exp_canon = 0, res_valid = 0, clear = 0;
  logic [31:0] exp_result = 0, exp_data1 = 0, exp_data2 = 0, res_result = 0;
  logic [4:0]  exp_flags = 0, res_flags = 0;
  logic        exp_ready, busy, halted, chk_valid, chk_fail, err_underflow;
  logic [31:0] pass_count, fail_count, err_data1, err_data2, err_expected, err_calculated;
  logic [4:0]  err_flags_exp, err_flags_calc;

  // Instance B: STOP_ON_FAIL=0
  logic        b_exp_valid = 0, b_exp_canon = 0, b_res_valid = 0, b_clear = 0;
  logic [31:0] b_exp_result = 0, b_exp_data1 = 0, b_exp_data2 = 0, b_res_result = 0;
  logic [4:0]  b_exp_flags = 0, b_res_flags = 0;
  logic        b_exp_ready, b_busy, b_halted, b_chk_valid, b_chk_fail, b_err_underflow;
  logic [31:0] b_pass_count, b_fail_count, b_err_data1, b_err_data2, b_err_expected, b_err_calculated;
  logic [4:0]  b_err_flags_exp, b_err_flags_calc;

  fp_result_checker #(.DEPTH(8), .CNT_W(32), .STOP_ON_FAIL(1)) dut (
    .clock(clock), .reset(reset),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_result(exp_result),
    .exp_flags(exp_flags), .exp_canon(exp_canon), .exp_data1(exp_data1), .exp_data2(exp_data2),
    .res_valid(res_valid), .res_result(res_result), .res_flags(res_flags), .clear(clear),
    .busy(busy), .halted(halted), .chk_valid(chk_valid), .chk_fail(chk_fail),
    .pass_count(pass_count), .fail_count(fail_count), .err_underflow(err_underflow),
    .err_data1(err_data1), .err_data2(err_data2), .err_expected(err_expected),
    .err_calculated(err_calculated), .err_flags_exp(err_flags_exp), .err_flags_calc(err_flags_calc)
  );

  fp_result_checker #(.DEPTH(8), .CNT_W(32), .STOP_ON_FAIL(0)) dut_b (
    .clock(clock), .reset(reset),
    .exp_valid(b_exp_valid), .exp_ready(b_exp_ready), .exp_result(b_exp_result),
    .exp_flags(b_exp_flags), .exp_canon(b_exp_canon), .exp_data1(b_exp_data1), .exp_data2(b_exp_data2),
    .res_valid(b_res_valid), .res_result(b_res_result), .res_flags(b_res_flags), .clear(b_clear),
    .busy(b_busy), .halted(b_halted), .chk_valid(b_chk_valid), .chk_fail(b_chk_fail),
    .pass_count(b_pass_count), .fail_count(b_fail_count), .err_underflow(b_err_underflow),
    .err_data1(b_err_data1), .err_data2(b_err_data2), .err_expected(b_err_expected),
    .err_calculated(b_err_calculated), .err_flags_exp(b_err_flags_exp), .err_flags_calc(b_err_flags_calc)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_exp(input logic v, input logic [31:0] r, input logic [4:0] f,
                         input logic c, input logic [31:0] d1, input logic [31:0] d2);
    exp_valid = v; exp_result = r; exp_flags = f; exp_canon = c; exp_data1 = d1; exp_data2 = d2;
  endtask

  task automatic set_res(input logic v, input logic [31:0] r, input logic [4:0] f);
    res_valid = v; res_result = r; res_flags = f;
  endtask

  task automatic pulse_clear();
    clear = 1; tick(); clear = 0;
  endtask

  initial begin
    // Reset values
    reset = 0; tick(); tick();
    check("rst_exp_ready", exp_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_chk_valid", chk_valid, 0);
    check("rst_chk_fail", chk_fail, 0);
    check("rst_pass", pass_count, 0);
    check("rst_fail", fail_count, 0);
    check("rst_underflow", err_underflow, 0);
    check("rst_err_expected", err_expected, 0);
    reset = 1; tick();

    // Basic pass, latency 1
    set_exp(1, 32'h3F800000, 5'h00, 1, 32'h1, 32'h2); tick(); set_exp(0, 0, 0, 0, 0, 0);
    check("push_nochk", chk_valid, 0);
    check("push_busy", busy, 1);
    set_res(1, 32'h3F800000, 5'h00); tick(); set_res(0, 0, 0);
    check("t1_chk_valid", chk_valid, 1);
    check("t1_chk_fail", chk_fail, 0);
    check("t1_pass", pass_count, 1);
    check("t1_busy", busy, 0);
    tick();
    check("t1_pulse_end", chk_valid, 0);

    // NaN masking
    set_exp(1, 32'h7FC00000, 5'h10, 1, 32'hA, 32'hB); tick();
    set_exp(1, 32'hFFC00001, 5'h10, 1, 32'hC, 32'hD); tick();
    set_exp(1, 32'hFFC00001, 5'h10, 0, 32'h11111111, 32'h22222222); tick();
    set_exp(0, 0, 0, 0, 0, 0);
    set_res(1, 32'h7FC00000, 5'h10); tick();
    check("nan_eq_fail", chk_fail, 0);
    check("nan_eq_pass", pass_count, 2);
    tick();
    check("nan_mask_fail", chk_fail, 0);
    check("nan_mask_pass", pass_count, 3);
    tick(); set_res(0, 0, 0);
    check("nan_nocanon_fail", chk_fail, 1);
    check("nan_nocanon_cnt", fail_count, 1);
    check("nan_err_expected", err_expected, 32'hFFC00001);
    check("nan_err_data1", err_data1, 32'h11111111);
    check("nan_halted", halted, 1);
    pulse_clear();
    check("nan_clear_halted", halted, 0);
    check("nan_clear_pass", pass_count, 0);

    // Flag mismatch halts; results ignored while halted
    set_exp(1, 32'h00000001, 5'h00, 0, 32'h3, 32'h4); tick(); set_exp(0, 0, 0, 0, 0, 0);
    set_res(1, 32'h00000001, 5'h10); tick(); set_res(0, 0, 0);
    check("flag_chk_fail", chk_fail, 1);
    check("flag_halted", halted, 1);
    check("flag_err_flags_calc", err_flags_calc, 5'h10);
    check("flag_err_flags_exp", err_flags_exp, 5'h00);
    check("flag_exp_ready", exp_ready, 0);
    set_res(1, 32'h5, 5'h1); tick(); set_res(0, 0, 0);
    check("halt_ignore_valid", chk_valid, 0);
    check("halt_ignore_fail", fail_count, 1);
    check("halt_ignore_uf", err_underflow, 0);
    pulse_clear();
    check("clr_halted", halted, 0);
    check("clr_fail", fail_count, 0);
    check("clr_err_flags_calc", err_flags_calc, 0);

    // Fill to full, then push+pop while full
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("fill7_ready", exp_ready, 1);
      set_exp(1, 32'h100 + i, 0, 0, 0, 0); tick();
    end
    set_exp(0, 0, 0, 0, 0, 0);
    check("full_ready", exp_ready, 0);
    set_exp(1, 32'hDEAD, 0, 0, 0, 0); set_res(1, 32'h100, 0); tick();
    set_exp(0, 0, 0, 0, 0, 0);
    check("full_pp_fail", chk_fail, 0);
    for (int i = 1; i < 8; i++) begin
      set_res(1, 32'h100 + i, 0); tick();
      check("drain_fail", {chk_valid, chk_fail}, 2'b10);
    end
    set_res(0, 0, 0);
    check("drain_busy", busy, 0);
    check("drain_pass", pass_count, 8);

    // Interleaved push/pop across pointer wrap
    for (int k = 0; k <= 20; k++) begin
      if (k < 20) set_exp(1, 32'h10000000 + k, 0, 0, 0, 0); else set_exp(0, 0, 0, 0, 0, 0);
      if (k > 0) set_res(1, 32'h10000000 + k - 1, 0); else set_res(0, 0, 0);
      tick();
      if (k > 0) check("wrap_cmp", {chk_valid, chk_fail}, 2'b10);
    end
    set_exp(0, 0, 0, 0, 0, 0); set_res(0, 0, 0);
    check("wrap_pass", pass_count, 28);
    check("wrap_fail", fail_count, 0);
    check("wrap_busy", busy, 0);

    // Underflow with simultaneous push
    set_exp(1, 32'h55, 0, 0, 0, 0); set_res(1, 32'hAAAA5555, 5'h03); tick();
    set_exp(0, 0, 0, 0, 0, 0); set_res(0, 0, 0);
    check("uf_flag", err_underflow, 1);
    check("uf_chk_fail", chk_fail, 1);
    check("uf_fail", fail_count, 1);
    check("uf_busy", busy, 1);
    check("uf_err_calc", err_calculated, 32'hAAAA5555);
    check("uf_err_fcalc", err_flags_calc, 5'h03);
    check("uf_err_expected", err_expected, 0);
    pulse_clear();
    check("uf_clr_underflow", err_underflow, 0);
    set_res(1, 32'h55, 0); tick(); set_res(0, 0, 0);
    check("uf_kept_entry", {chk_valid, chk_fail}, 2'b10);
    check("uf_kept_busy", busy, 0);

    // Non-halting instance: first failure snapshot held
    for (int i = 0; i < 5; i++) begin
      b_exp_valid = 1; b_exp_result = 32'h11 + 32'h10 * i; b_exp_canon = 0;
      b_exp_flags = (i == 2) ? 5'h01 : 5'h00;
      b_exp_data1 = 32'hA1 + i; b_exp_data2 = 32'hB1 + i;
      tick();
    end
    b_exp_valid = 0;
    for (int i = 0; i < 5; i++) begin
      b_res_valid = 1; b_res_flags = 0;
      b_res_result = 32'h11 + 32'h10 * i + ((i < 2) ? 32'h3 : 32'h0);
      tick();
      check("b_chk_fail", b_chk_fail, (i < 3) ? 1 : 0);
    end
    b_res_valid = 0;
    check("b_fail", b_fail_count, 3);
    check("b_pass", b_pass_count, 2);
    check("b_halted", b_halted, 0);
    check("b_err_data1", b_err_data1, 32'hA1);
    check("b_err_data2", b_err_data2, 32'hB1);
    check("b_err_expected", b_err_expected, 32'h11);
    check("b_err_calc", b_err_calculated, 32'h14);

    // Reset mid-stream
    b_exp_valid = 1; b_exp_result = 32'h77; tick();
    b_res_valid = 1; b_res_result = 32'h77; reset = 0; tick();
    b_exp_valid = 0; b_res_valid = 0;
    check("b_rst_busy", b_busy, 0);
    check("b_rst_pass", b_pass_count, 0);
    check("b_rst_fail", b_fail_count, 0);
    check("b_rst_chk_valid", b_chk_valid, 0);
    check("b_rst_exp_ready", b_exp_ready, 1);
    check("b_rst_err_expected", b_err_expected, 0);
    check("b_rst_err_data1", b_err_data1, 0);
    reset = 1; tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
